mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter and sequencer for the shared main memory. The CPU and the VGA framebuffer fetcher both reach Mem through this block. It grants one requester at a time and drives the Memread/Memwrite/Addr strobes to Mem for exactly one cycle. It waits the fixed memory latency, then returns read data and a one-cycle acknowledge to the winner. It sits between CPU, VGA and Mem in the top level. It replaces direct CPU-to-Mem wiring and the shared tri-state BUS with separate read and write data paths.

## Interface
- MEM_LAT, 2: cycles from the memory strobe cycle to valid mem_rdata (≥1).
- MAX_WAIT, 4: consecutive lost arbitrations after which a waiting CPU request wins even against vga_urgent (≥1).
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU request, held high until cpu_ack.
- cpu_addr  in  32  CPU byte address.
- cpu_wsize  in  2  00 read, 01 byte write, 10 halfword write, 11 word write.
- cpu_wdata  in  32  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- cpu_rdata  out  32  read data, valid while cpu_ack is high and held until the next CPU ack.
- vga_req  in  1  VGA read request, held until vga_ack.
- vga_addr  in  32  VGA byte address.
- vga_urgent  in  1  VGA line buffer is near underflow.
- vga_ack  out  1  one-cycle completion pulse to VGA.
- vga_rdata  out  32  read data, same validity rule as cpu_rdata.
- mem_read  out  1  Memread strobe to Mem.
- mem_write  out  2  Memwrite size to Mem; 00 means no write.
- mem_addr  out  32  Addr to Mem.
- mem_wdata  out  32  write data to Mem.
- mem_rdata  in  32  data from Mem, valid MEM_LAT cycles after the strobe.
- busy  out  1  high in every state except IDLE.
- owner  out  1  last or current grant holder: 0 CPU, 1 VGA.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request is present, choose a winner, register the winner's address, wdata and wsize, update owner, and go to ISSUE. With no request, stay in IDLE.
- Arbitration priority, highest first:
  1. cpu_req && starve_cnt==MAX_WAIT → CPU.
  2. vga_req && vga_urgent → VGA.
  3. Both requesting → round-robin: the winner is the opposite of owner. owner resets to 1, so the CPU wins the first tie.
  4. A single requester wins.
- starve_cnt: increments by 1, saturating at MAX_WAIT, when VGA is granted while cpu_req is high. It clears to 0 when the CPU is granted.
- ISSUE (1 cycle):
  - mem_addr carries the registered address.
  - A VGA grant or a CPU grant with cpu_wsize 00 asserts mem_read=1.
  - Any other CPU grant drives mem_write with the registered wsize and mem_wdata with the registered data.
  - In every other state, mem_read=0 and mem_write=00. mem_addr and mem_wdata hold their last values.
- WAIT: a counter runs from MEM_LAT-1 down to 0. When it is 0, mem_rdata is captured into the winner's rdata register and the FSM goes to RESP.
- RESP (1 cycle): the winner's ack is 1. Requests are not sampled. Next state is IDLE.
- Writes follow the same path and timing as reads. For writes, rdata is captured anyway.
- Requesters drop req, or present a new request, at the edge that ends their ack cycle. The arbiter samples again in the following IDLE cycle.
- The losing request stays pending with no timeout.

## Timing
- Request high in IDLE cycle 0 → ISSUE in cycle 1 → WAIT in cycles 2..MEM_LAT+1 → ack in cycle MEM_LAT+2.
- Latency from request to ack is MEM_LAT+2 cycles. Back-to-back throughput is one transaction per MEM_LAT+3 cycles.
- Simultaneous requests: only one is granted per IDLE cycle. The loser is granted at the next IDLE if it still wins arbitration.
- Reset values while rst=0:
  - state IDLE
  - mem_read 0, mem_write 00, mem_addr 0, mem_wdata 0
  - cpu_ack 0, vga_ack 0, cpu_rdata 0, vga_rdata 0
  - busy 0, owner 1, starve_cnt 0
- Reset mid-transaction abandons it. No ack is issued and no strobe is generated after the reset cycle.
- Requests held through reset are arbitrated in the first cycle after rst returns high.

## Test plan
- CPU read, MEM_LAT=2, cpu_addr 0x100, Mem returns 0xDEADBEEF → mem_read=1 with addr 0x100 in cycle 1; cpu_ack=1 and cpu_rdata=0xDEADBEEF in cycle 4; vga_ack stays 0.
- CPU word write, cpu_addr 0x40, cpu_wdata 0x12345678, cpu_wsize 11 → one ISSUE cycle with mem_write=11, mem_addr 0x40, mem_wdata 0x12345678; mem_read=0; cpu_ack in cycle 4.
- cpu_req and vga_req both high from reset, vga_urgent=0 → CPU is acked first, then VGA, alternating; each ack occurs exactly 5 cycles after the previous one.
- vga_urgent and both requests held high, MAX_WAIT=4 → four consecutive VGA grants, then the CPU is granted on the fifth; starve_cnt returns to 0.
- rst driven low during WAIT of a VGA read → no vga_ack; every output is 0 and owner is 1 on the next cycle; after release, a pending cpu_req is issued one cycle later.
- vga_req pulses while a CPU transaction is in flight → it is not granted until the IDLE cycle after cpu_ack; busy is high for the entire CPU transaction.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates between the CPU and the VGA framebuffer fetcher for the shared
// main memory. Each transaction drives a single strobe cycle to Mem, waits
// the fixed memory latency, then returns read data with a one-cycle ack.
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   cpu_req/addr/wsize/wdata      CPU request (wsize 00 = read, else write size)
//   cpu_ack, cpu_rdata            CPU completion pulse and captured data
//   vga_req/addr/urgent           VGA read request and underflow hint
//   vga_ack, vga_rdata            VGA completion pulse and captured data
//   mem_read/write/addr/wdata     strobes and operands to Mem
//   mem_rdata                     data from Mem, valid MEM_LAT cycles after the strobe
//   busy                          high whenever the sequencer is not IDLE
//   owner                         last or current grant holder (0 CPU, 1 VGA)
module mem_arbiter #(
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [1:0]  cpu_wsize,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    input  logic        vga_req,
    input  logic [31:0] vga_addr,
    input  logic        vga_urgent,
    output logic        vga_ack,
    output logic [31:0] vga_rdata,
    output logic        mem_read,
    output logic [1:0]  mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = $clog2(MAX_WAIT + 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(MAX_WAIT);
    localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic               grant_s;
    logic               pick_vga_s;
    logic               lat_done_s;
    logic               grant_vga_r;
    logic [LAT_W-1:0]   lat_cnt_r;
    logic [STV_W-1:0]   starve_cnt_r;

    // Winner selection: starved CPU, then urgent VGA, then alternate on a tie.
    always_comb begin
        grant_s    = cpu_req | vga_req;
        pick_vga_s = 1'b0;
        if (cpu_req && (starve_cnt_r == STV_MAX)) begin
            pick_vga_s = 1'b0;
        end else if (vga_req && vga_urgent) begin
            pick_vga_s = 1'b1;
        end else if (cpu_req && vga_req) begin
            pick_vga_s = ~owner;
        end else begin
            // Only one requester (or none, which grant_s already masks).
            pick_vga_s = vga_req;
        end
    end

    // Next-state logic for the IDLE/ISSUE/WAIT/RESP sequencer.
    always_comb begin
        next_state_s = state_r;
        lat_done_s   = (lat_cnt_r == {LAT_W{1'b0}});
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: next_state_s = WAIT;
            WAIT: begin
                if (lat_done_s) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = WAIT;
                end
            end
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered datapath: grant capture, memory strobes, latency count, acks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_read     <= 1'b0;
            mem_write    <= 2'b00;
            mem_addr     <= 32'h0000_0000;
            mem_wdata    <= 32'h0000_0000;
            cpu_ack      <= 1'b0;
            vga_ack      <= 1'b0;
            cpu_rdata    <= 32'h0000_0000;
            vga_rdata    <= 32'h0000_0000;
            busy         <= 1'b0;
            owner        <= 1'b1;
            grant_vga_r  <= 1'b0;
            lat_cnt_r    <= {LAT_W{1'b0}};
            starve_cnt_r <= {STV_W{1'b0}};
        end else begin
            // Strobes and acks are single-cycle pulses; default them low.
            mem_read  <= 1'b0;
            mem_write <= 2'b00;
            cpu_ack   <= 1'b0;
            vga_ack   <= 1'b0;
            busy      <= (next_state_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        grant_vga_r <= pick_vga_s;
                        owner       <= pick_vga_s;
                        if (pick_vga_s) begin
                            mem_addr <= vga_addr;
                            mem_read <= 1'b1;
                            // Only count losses the CPU actually suffered.
                            if (cpu_req && (starve_cnt_r != STV_MAX)) begin
                                starve_cnt_r <= starve_cnt_r + STV_ONE;
                            end else begin
                                starve_cnt_r <= starve_cnt_r;
                            end
                        end else begin
                            mem_addr     <= cpu_addr;
                            starve_cnt_r <= {STV_W{1'b0}};
                            if (cpu_wsize == 2'b00) begin
                                mem_read <= 1'b1;
                            end else begin
                                // mem_wdata keeps its old value on reads.
                                mem_write <= cpu_wsize;
                                mem_wdata <= cpu_wdata;
                            end
                        end
                    end
                end
                ISSUE: begin
                    lat_cnt_r <= LAT_INIT;
                end
                WAIT: begin
                    if (lat_cnt_r == {LAT_W{1'b0}}) begin
                        // Capture even for writes; the ack carries whatever Mem returned.
                        if (grant_vga_r) begin
                            vga_rdata <= mem_rdata;
                            vga_ack   <= 1'b1;
                        end else begin
                            cpu_rdata <= mem_rdata;
                            cpu_ack   <= 1'b1;
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r - LAT_ONE;
                    end
                end
                RESP: begin
                    lat_cnt_r <= lat_cnt_r;
                end
                default: begin
                    lat_cnt_r <= {LAT_W{1'b0}};
                end
            endcase
        end
    end

endmodule
